// File: rtl/mc_ctrl_fsm.sv
// Multicycle IF/ID/EX/MEM/WB control unit with a memory ready handshake,
// a stall watchdog and a sticky TRAP state for illegal opcodes and timeouts.
module mc_ctrl_fsm #(
    parameter int unsigned ALU_CNTRL_W = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   instrReg,
    output logic                   PCReg,
    output logic                   R_rsReg,
    output logic                   R_rtReg,
    output logic                   addrGen,
    output logic                   RegWr,
    output logic                   MemWr,
    output logic [1:0]             RegDst,
    output logic                   ALUSrc,
    output logic [ALU_CNTRL_W-1:0] ALUcntrl,
    output logic [1:0]             MemToReg,
    output logic                   jump,
    output logic                   beq,
    output logic                   bne,
    output logic                   illegal,
    output logic                   timeout,
    output logic [2:0]             state_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic WD_ON = (MEM_TIMEOUT != 0);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] alu;
        logic [1:0] mem_to_reg;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       wb;
        logic       mem;
        logic       store;
    } dec_t;

    state_t           state;
    state_t           id_next;
    dec_t             dec_q;
    dec_t             dec_n;
    logic             id_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             in_mem_phase;
    logic             expire;

    assign in_mem_phase = (state == S_IF) || (state == S_MEM);
    // A ready in the expiry cycle completes the access instead of trapping.
    assign expire = WD_ON && in_mem_phase && !mem_ready && (stall_cnt == CNT_MAX);

    always_comb begin
        dec_n   = '0;
        id_next = S_TRAP;
        id_pc   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        dec_n.alu = ALU_ADD;
                        dec_n.wb  = 1'b1;
                        id_next   = S_EX;
                    end
                    FN_SUB: begin
                        dec_n.alu = ALU_SUB;
                        dec_n.wb  = 1'b1;
                        id_next   = S_EX;
                    end
                    FN_SLT: begin
                        dec_n.alu = ALU_SLT;
                        dec_n.wb  = 1'b1;
                        id_next   = S_EX;
                    end
                    FN_JR: begin
                        dec_n.jump = 1'b1;
                        id_pc      = 1'b1;
                        id_next    = S_IF;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                dec_n.reg_dst    = 2'd2;
                dec_n.alu_src    = 1'b1;
                dec_n.alu        = ALU_ADD;
                dec_n.mem_to_reg = 2'd1;
                dec_n.wb         = 1'b1;
                dec_n.mem        = 1'b1;
                id_next          = S_EX;
            end
            OP_SW: begin
                dec_n.alu_src = 1'b1;
                dec_n.mem     = 1'b1;
                dec_n.store   = 1'b1;
                id_next       = S_EX;
            end
            OP_BEQ: begin
                dec_n.alu = ALU_SUB;
                dec_n.beq = 1'b1;
                id_next   = S_EX;
            end
            OP_BNE: begin
                dec_n.alu = ALU_SUB;
                dec_n.bne = 1'b1;
                id_next   = S_EX;
            end
            OP_XORI: begin
                dec_n.reg_dst = 2'd2;
                dec_n.alu_src = 1'b1;
                dec_n.alu     = ALU_XOR;
                dec_n.wb      = 1'b1;
                id_next       = S_EX;
            end
            OP_ADDI: begin
                dec_n.reg_dst = 2'd2;
                dec_n.alu_src = 1'b1;
                dec_n.alu     = ALU_ADD;
                dec_n.wb      = 1'b1;
                id_next       = S_EX;
            end
            OP_JAL: begin
                dec_n.reg_dst    = 2'd1;
                dec_n.mem_to_reg = 2'd2;
                dec_n.jump       = 1'b1;
                dec_n.wb         = 1'b1;
                id_next          = S_WB;
            end
            OP_J: begin
                dec_n.jump = 1'b1;
                id_pc      = 1'b1;
                id_next    = S_IF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IF;
            dec_q     <= '0;
            stall_cnt <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                S_IF: begin
                    if (mem_ready) begin
                        state <= S_ID;
                    end else if (expire) begin
                        state   <= S_TRAP;
                        timeout <= 1'b1;
                    end
                end
                S_ID: begin
                    dec_q <= dec_n;
                    state <= id_next;
                    if (id_next == S_TRAP) begin
                        illegal <= 1'b1;
                    end
                end
                S_EX: begin
                    if (dec_q.mem) begin
                        state <= S_MEM;
                    end else if (dec_q.wb) begin
                        state <= S_WB;
                    end else begin
                        state <= S_IF;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= dec_q.wb ? S_WB : S_IF;
                    end else if (expire) begin
                        state   <= S_TRAP;
                        timeout <= 1'b1;
                    end
                end
                S_WB:    state <= S_IF;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_IF;
            endcase

            if (WD_ON && in_mem_phase && !mem_ready && !expire) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    // Strobes are decoded from state and decode register, and gated by reset.
    always_comb begin
        mem_req  = 1'b0;
        instrReg = 1'b0;
        PCReg    = 1'b0;
        R_rsReg  = 1'b0;
        R_rtReg  = 1'b0;
        addrGen  = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        if (!reset) begin
            case (state)
                S_IF: begin
                    mem_req  = 1'b1;
                    instrReg = 1'b1;
                    PCReg    = mem_ready;
                end
                S_ID: begin
                    R_rsReg = 1'b1;
                    R_rtReg = 1'b1;
                    addrGen = 1'b1;
                    PCReg   = id_pc;
                end
                S_EX: begin
                    PCReg = dec_q.beq | dec_q.bne;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    MemWr   = dec_q.store;
                end
                S_WB: begin
                    RegWr = 1'b1;
                    PCReg = dec_q.jump;
                end
                default: ;
            endcase
        end
    end

    assign state_o  = state;
    assign RegDst   = dec_q.reg_dst;
    assign ALUSrc   = dec_q.alu_src;
    assign ALUcntrl = ALU_CNTRL_W'(dec_q.alu);
    assign MemToReg = dec_q.mem_to_reg;
    assign jump     = dec_q.jump;
    assign beq      = dec_q.beq;
    assign bne      = dec_q.bne;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction class expands to a stage path string
// with stall counts; every cycle's state, strobes and decode outputs are checked.
module tb_mc_ctrl_fsm;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, instrReg, PCReg, R_rsReg, R_rtReg, addrGen, RegWr, MemWr;
    logic [1:0] RegDst;
    logic       ALUSrc;
    logic [2:0] ALUcntrl;
    logic [1:0] MemToReg;
    logic       jump, beq, bne, illegal, timeout;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_bad = 0;

    logic [10:0] cur_dec;
    logic        exp_ill;
    logic        exp_to;

    mc_ctrl_fsm #(.ALU_CNTRL_W(3), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .instrReg(instrReg), .PCReg(PCReg), .R_rsReg(R_rsReg),
        .R_rtReg(R_rtReg), .addrGen(addrGen), .RegWr(RegWr), .MemWr(MemWr),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUcntrl(ALUcntrl), .MemToReg(MemToReg),
        .jump(jump), .beq(beq), .bne(bne), .illegal(illegal), .timeout(timeout),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] strobes();
        return {mem_req, instrReg, PCReg, R_rsReg, R_rtReg, addrGen, RegWr, MemWr};
    endfunction

    function automatic logic [10:0] dec_out();
        return {RegDst, ALUSrc, ALUcntrl, MemToReg, jump, beq, bne};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive mem_ready, check everything mid-cycle, then advance.
    task automatic cyc(input logic rdy, input logic [2:0] st, input logic [7:0] sb, input string tag);
        mem_ready = rdy;
        #2;
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_strobes"}, 32'(strobes()), 32'(sb));
        chk({tag, "_decode"}, 32'(dec_out()), 32'(cur_dec));
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            mem_ready = 1'($urandom);
            #2;
            chk("reset_strobes", 32'(strobes()), 32'd0);
            @(posedge clk);
            #1;
        end
        reset   = 1'b0;
        cur_dec = '0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) cyc(1'($urandom), 3'd5, 8'h00, "trap");
        do_reset(2);
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0e, 6'h23, 6'h2b};
    endfunction

    // Decode vector layout: {RegDst[1:0], ALUSrc, ALUcntrl[2:0], MemToReg[1:0], jump, beq, bne}
    task automatic kind_info(input int k, input int forced_op, output logic [5:0] op,
                             output logic [5:0] fn, output string path, output logic [10:0] dec);
        fn  = 6'($urandom);
        dec = '0;
        case (k)
            0:  begin op = 6'h00; fn = 6'h20; path = "FDEW"; end
            1:  begin op = 6'h00; fn = 6'h22; path = "FDEW"; dec = {2'd0, 1'b0, 3'd1, 2'd0, 3'b000}; end
            2:  begin op = 6'h00; fn = 6'h2a; path = "FDEW"; dec = {2'd0, 1'b0, 3'd3, 2'd0, 3'b000}; end
            3:  begin op = 6'h23; path = "FDEMW"; dec = {2'd2, 1'b1, 3'd0, 2'd1, 3'b000}; end
            4:  begin op = 6'h2b; path = "FDEM";  dec = {2'd0, 1'b1, 3'd0, 2'd0, 3'b000}; end
            5:  begin op = 6'h04; path = "FDE";   dec = {2'd0, 1'b0, 3'd1, 2'd0, 3'b010}; end
            6:  begin op = 6'h05; path = "FDE";   dec = {2'd0, 1'b0, 3'd1, 2'd0, 3'b001}; end
            7:  begin op = 6'h0e; path = "FDEW";  dec = {2'd2, 1'b1, 3'd2, 2'd0, 3'b000}; end
            8:  begin op = 6'h08; path = "FDEW";  dec = {2'd2, 1'b1, 3'd0, 2'd0, 3'b000}; end
            9:  begin op = 6'h03; path = "FDW";   dec = {2'd1, 1'b0, 3'd0, 2'd2, 3'b100}; end
            10: begin op = 6'h02; path = "FD";    dec = {2'd0, 1'b0, 3'd0, 2'd0, 3'b100}; end
            11: begin op = 6'h00; fn = 6'h08; path = "FD"; dec = {2'd0, 1'b0, 3'd0, 2'd0, 3'b100}; end
            12: begin
                path = "FDT";
                if (forced_op >= 0) op = 6'(forced_op);
                else begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
            end
            default: begin
                path = "FDT";
                op   = 6'h00;
                while (fn inside {6'h20, 6'h22, 6'h2a, 6'h08}) fn = 6'($urandom);
            end
        endcase
    endtask

    // abort_at >= 0 pulses reset on that MEM stall cycle instead of completing.
    task automatic run_instr(input int k, input int if_st, input int mem_st,
                             input int forced_op, input int abort_at);
        logic [5:0]  op, fn;
        logic [10:0] dec;
        string       path;
        bit          store, jj, br, jal;
        kind_info(k, forced_op, op, fn, path, dec);
        opcode = op;
        funct  = fn;
        store  = (k == 4);
        jj     = (k == 10) || (k == 11);
        br     = (k == 5) || (k == 6);
        jal    = (k == 9);
        for (int p = 0; p < path.len(); p++) begin
            case (path[p])
                "F", "M": begin
                    bit   is_f  = (path[p] == "F");
                    int   n     = is_f ? if_st : mem_st;
                    int   lim   = (n > TO) ? TO + 1 : n;
                    logic [2:0] st  = is_f ? 3'd0 : 3'd3;
                    logic [7:0] sbs = is_f ? 8'b1100_0000 : {1'b1, 6'b0, store};
                    logic [7:0] sbr = is_f ? 8'b1110_0000 : {1'b1, 6'b0, store};
                    for (int c = 0; c < lim; c++) begin
                        if (!is_f && c == abort_at) begin
                            reset     = 1'b1;
                            mem_ready = 1'b0;
                            #2;
                            chk("rst_mid_strobes", 32'(strobes()), 32'd0);
                            @(posedge clk);
                            #1;
                            reset   = 1'b0;
                            cur_dec = '0;
                            exp_ill = 1'b0;
                            exp_to  = 1'b0;
                            chk("rst_mid_state", 32'(state_o), 32'd0);
                            return;
                        end
                        cyc(1'b0, st, sbs, is_f ? "if_stall" : "mem_stall");
                    end
                    if (n > TO) begin
                        exp_to = 1'b1;
                        trap_hold(20);
                        return;
                    end
                    cyc(1'b1, st, sbr, is_f ? "if_ready" : "mem_ready");
                end
                "D": begin
                    cyc(1'($urandom), 3'd1, 8'b0001_1100 | (jj ? 8'b0010_0000 : 8'h00), "id");
                    cur_dec = dec;
                    if (path[path.len()-1] == "T") exp_ill = 1'b1;
                end
                "E": cyc(1'($urandom), 3'd2, br ? 8'b0010_0000 : 8'h00, "ex");
                "W": cyc(1'($urandom), 3'd4, 8'b0000_0010 | (jal ? 8'b0010_0000 : 8'h00), "wb");
                default: begin
                    trap_hold(20);
                    return;
                end
            endcase
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = '0;
        funct     = '0;
        mem_ready = 1'b0;
        cur_dec   = '0;
        exp_ill   = 1'b0;
        exp_to    = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        run_instr(0, 0, 0, -1, -1);   // ADD, ready throughout
        run_instr(3, 0, 3, -1, -1);   // LW with 3 MEM stalls
        run_instr(4, 0, 0, -1, -1);   // SW
        run_instr(9, 0, 0, -1, -1);   // JAL
        run_instr(12, 0, 0, 63, -1);  // opcode 0x3f traps
        run_instr(0, 16, 0, -1, -1);  // IF watchdog expiry
        run_instr(0, 15, 0, -1, -1);  // ready on the expiry cycle
        run_instr(4, 0, 4, -1, 1);    // reset on second SW MEM stall
        run_instr(3, 0, 20, -1, -1);  // MEM watchdog expiry
        run_instr(3, 0, 15, -1, -1);
        run_instr(13, 1, 0, -1, -1);  // illegal R-type funct
        run_instr(11, 0, 0, -1, -1);  // JR
        run_instr(10, 2, 0, -1, -1);  // J

        for (int i = 0; i < 300; i++) begin
            int k    = int'($urandom_range(0, 11));
            int ifs  = int'($urandom_range(0, 3));
            int mems = int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) k = 12 + int'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) ifs = int'($urandom_range(13, 17));
            if ($urandom_range(0, 29) == 0) mems = int'($urandom_range(13, 17));
            run_instr(k, ifs, mems, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
